// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: MMCM reset pulse, lock qualification, IDELAYCTRL wait,
// then staged release of IO and core resets; restarts on lock loss or timeout.
module rst_seq_ctrl #(
  parameter int MMCM_RST_CYC     = 8,
  parameter int LOCK_STABLE_CYC  = 32768,
  parameter int IDLY_TIMEOUT_CYC = 65536,
  parameter int STAGE_GAP_CYC    = 16
) (
  input  logic       sys_clk_bufg,
  input  logic       rst_n,
  input  logic       mmcm_locked,
  input  logic       idelay_rdy,
  output logic       rst_mmcm,
  output logic       rst_glb,
  output logic       rst_io_n,
  output logic       rst_core_n,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_cnt,
  output logic       err_idelay_to
);

  localparam int MAX_AB  = (MMCM_RST_CYC > LOCK_STABLE_CYC) ? MMCM_RST_CYC : LOCK_STABLE_CYC;
  localparam int MAX_CD  = (IDLY_TIMEOUT_CYC > STAGE_GAP_CYC) ? IDLY_TIMEOUT_CYC : STAGE_GAP_CYC;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MMCM_LAST   = CNT_W'(MMCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLY_LAST   = CNT_W'(IDLY_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_IDLY      = 3'd3,
    ST_REL_IO    = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  // bit 0: mmcm_locked, bit 1: idelay_rdy
  logic [1:0] sync_meta_reg;
  logic [1:0] sync_out_reg;
  logic       locked_s;
  logic       rdy_s;

  always_ff @(posedge sys_clk_bufg or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_reg <= 2'b00;
      sync_out_reg  <= 2'b00;
    end else begin
      sync_meta_reg <= {idelay_rdy, mmcm_locked};
      sync_out_reg  <= sync_meta_reg;
    end
  end

  assign locked_s = sync_out_reg[0];
  assign rdy_s    = sync_out_reg[1];

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             lock_lost;
  logic             idly_to;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    lock_lost  = 1'b0;
    idly_to    = 1'b0;
    case (state_reg)
      ST_MMCM_RST: begin
        if (cnt_reg == MMCM_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        cnt_next = '0;
        if (locked_s) state_next = ST_STABLE;
      end
      ST_STABLE: begin
        // A glitch before release just restarts qualification; not a lock loss.
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_IDLY;
          cnt_next   = '0;
        end
      end
      ST_IDLY: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (rdy_s) begin
          state_next = ST_REL_IO;
          cnt_next   = '0;
        end else if (cnt_reg == IDLY_LAST) begin
          state_next = ST_MMCM_RST;
          cnt_next   = '0;
          idly_to    = 1'b1;
        end
      end
      ST_REL_IO: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (cnt_reg == GAP_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        cnt_next = '0;
        if (!locked_s) lock_lost = 1'b1;
      end
      default: begin
        state_next = ST_MMCM_RST;
        cnt_next   = '0;
      end
    endcase
    // Lock loss overrides any timeout or stage completion on the same cycle.
    if (lock_lost) begin
      state_next = ST_MMCM_RST;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge sys_clk_bufg or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_MMCM_RST;
      cnt_reg       <= '0;
      seq_state     <= 3'd0;
      rst_mmcm      <= 1'b1;
      rst_glb       <= 1'b1;
      rst_io_n      <= 1'b0;
      rst_core_n    <= 1'b0;
      lock_loss_cnt <= 8'd0;
      err_idelay_to <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      seq_state  <= state_next;
      rst_mmcm   <= (state_next == ST_MMCM_RST);
      rst_glb    <= (state_next == ST_MMCM_RST) || (state_next == ST_WAIT_LOCK) ||
                    (state_next == ST_STABLE);
      rst_io_n   <= (state_next == ST_REL_IO) || (state_next == ST_RUN);
      rst_core_n <= (state_next == ST_RUN);
      if (lock_lost && (lock_loss_cnt != 8'hFF)) lock_loss_cnt <= lock_loss_cnt + 8'd1;
      if (idly_to) err_idelay_to <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected per-cycle snapshots are queued
// with the stimulus and compared at the falling clock edge.
module tb_rst_seq_ctrl;

  logic       sys_clk_bufg = 1'b0;
  logic       rst_n        = 1'b1;
  logic       mmcm_locked  = 1'b0;
  logic       idelay_rdy   = 1'b0;
  logic       rst_mmcm;
  logic       rst_glb;
  logic       rst_io_n;
  logic       rst_core_n;
  logic [2:0] seq_state;
  logic [7:0] lock_loss_cnt;
  logic       err_idelay_to;

  rst_seq_ctrl #(
    .MMCM_RST_CYC    (8),
    .LOCK_STABLE_CYC (16),
    .IDLY_TIMEOUT_CYC(64),
    .STAGE_GAP_CYC   (4)
  ) dut (
    .sys_clk_bufg (sys_clk_bufg),
    .rst_n        (rst_n),
    .mmcm_locked  (mmcm_locked),
    .idelay_rdy   (idelay_rdy),
    .rst_mmcm     (rst_mmcm),
    .rst_glb      (rst_glb),
    .rst_io_n     (rst_io_n),
    .rst_core_n   (rst_core_n),
    .seq_state    (seq_state),
    .lock_loss_cnt(lock_loss_cnt),
    .err_idelay_to(err_idelay_to)
  );

  always #5 sys_clk_bufg = ~sys_clk_bufg;

  int cyc = 0;
  always @(posedge sys_clk_bufg) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [7:0] llc;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   base   = 0;

  function automatic void push_range(int from, int to, logic [2:0] st, logic [7:0] llc,
                                     logic err, string tag);
    for (int c = from; c <= to; c++) begin
      exp_t e;
      e.cyc = base + c;
      e.st  = st;
      e.llc = llc;
      e.err = err;
      e.tag = tag;
      sb.push_back(e);
    end
  endfunction

  task automatic wait_until(int c);
    while (cyc < c) @(negedge sys_clk_bufg);
  endtask

  task automatic monitor();
    forever begin
      @(negedge sys_clk_bufg);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic exp_mmcm, exp_glb, exp_io, exp_core;
        e        = sb.pop_front();
        exp_mmcm = (e.st == 3'd0);
        exp_glb  = (e.st <= 3'd2);
        exp_io   = (e.st >= 3'd4);
        exp_core = (e.st == 3'd5);
        checks++;
        if (seq_state !== e.st || rst_mmcm !== exp_mmcm || rst_glb !== exp_glb ||
            rst_io_n !== exp_io || rst_core_n !== exp_core ||
            lock_loss_cnt !== e.llc || err_idelay_to !== e.err) begin
          errors++;
          $display("FAIL %s cycle %0d: got st=%0d mmcm=%b glb=%b io_n=%b core_n=%b llc=%0d err=%b, want st=%0d mmcm=%b glb=%b io_n=%b core_n=%b llc=%0d err=%b",
                   e.tag, e.cyc - base, seq_state, rst_mmcm, rst_glb, rst_io_n, rst_core_n,
                   lock_loss_cnt, err_idelay_to, e.st, exp_mmcm, exp_glb, exp_io, exp_core,
                   e.llc, e.err);
        end
      end
    end
  endtask

  task automatic test_reset();
    #12 rst_n = 1'b0;
    #1;
    checks++;
    if (seq_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", seq_state); end
    checks++;
    if (rst_mmcm !== 1'b1) begin errors++; $display("FAIL reset_mmcm: got %b want 1", rst_mmcm); end
    checks++;
    if (rst_glb !== 1'b1) begin errors++; $display("FAIL reset_glb: got %b want 1", rst_glb); end
    checks++;
    if (rst_io_n !== 1'b0 || rst_core_n !== 1'b0) begin
      errors++; $display("FAIL reset_io_core: got %b%b want 00", rst_io_n, rst_core_n);
    end
    checks++;
    if (lock_loss_cnt !== 8'd0 || err_idelay_to !== 1'b0) begin
      errors++; $display("FAIL reset_status: got llc=%0d err=%b want 0 0", lock_loss_cnt, err_idelay_to);
    end
    $display("test_reset: outputs sampled during async reset");
  endtask

  task automatic test_bringup();
    @(negedge sys_clk_bufg);
    base = cyc + 1;
    push_range(0, 7, 3'd0, 8'd0, 1'b0, "bringup_mmcm");
    push_range(8, 22, 3'd1, 8'd0, 1'b0, "bringup_wait");
    push_range(23, 38, 3'd2, 8'd0, 1'b0, "bringup_stable");
    push_range(39, 51, 3'd3, 8'd0, 1'b0, "bringup_idly");
    push_range(52, 55, 3'd4, 8'd0, 1'b0, "bringup_rel_io");
    push_range(56, 60, 3'd5, 8'd0, 1'b0, "bringup_run");
    @(negedge sys_clk_bufg);
    rst_n = 1'b1;
    wait_until(base + 20);
    mmcm_locked = 1'b1;
    wait_until(base + 49);
    idelay_rdy = 1'b1;
    wait_until(base + 60);
    $display("test_bringup: lock at 20, rdy at 49, run expected at 56");
  endtask

  task automatic test_lock_glitch();
    @(negedge sys_clk_bufg);
    rst_n       = 1'b0;
    mmcm_locked = 1'b0;
    idelay_rdy  = 1'b0;
    @(negedge sys_clk_bufg);
    base = cyc + 1;
    push_range(0, 7, 3'd0, 8'd0, 1'b0, "glitch_mmcm");
    push_range(8, 22, 3'd1, 8'd0, 1'b0, "glitch_wait");
    push_range(23, 32, 3'd2, 8'd0, 1'b0, "glitch_stable1");
    push_range(33, 35, 3'd1, 8'd0, 1'b0, "glitch_relock");
    push_range(36, 51, 3'd2, 8'd0, 1'b0, "glitch_stable2");
    push_range(52, 52, 3'd3, 8'd0, 1'b0, "glitch_idly");
    @(negedge sys_clk_bufg);
    rst_n = 1'b1;
    wait_until(base + 20);
    mmcm_locked = 1'b1;
    wait_until(base + 30);
    mmcm_locked = 1'b0;
    wait_until(base + 33);
    mmcm_locked = 1'b1;
    wait_until(base + 52);
    $display("test_lock_glitch: 3-cycle drop in STABLE, release expected at 52");
  endtask

  task automatic test_idelay_timeout();
    push_range(53, 115, 3'd3, 8'd0, 1'b0, "to_idly_wait");
    push_range(116, 123, 3'd0, 8'd0, 1'b1, "to_mmcm_repulse");
    push_range(124, 124, 3'd1, 8'd0, 1'b1, "to_wait");
    push_range(125, 140, 3'd2, 8'd0, 1'b1, "to_stable");
    push_range(141, 147, 3'd3, 8'd0, 1'b1, "to_idly");
    push_range(148, 151, 3'd4, 8'd0, 1'b1, "to_rel_io");
    push_range(152, 155, 3'd5, 8'd0, 1'b1, "to_run");
    wait_until(base + 145);
    idelay_rdy = 1'b1;
    wait_until(base + 155);
    $display("test_idelay_timeout: timeout expected at 116, flag held through rerun");
  endtask

  task automatic test_lock_loss_run();
    int d;
    int llc_model;
    d         = base + 157;
    llc_model = 0;
    for (int i = 0; i < 300; i++) begin
      int         post;
      logic [7:0] pre_v;
      logic [7:0] post_v;
      int         saved_base;
      post       = (llc_model < 255) ? llc_model + 1 : 255;
      pre_v      = 8'(llc_model);
      post_v     = 8'(post);
      wait_until(d);
      saved_base = base;
      base       = d;
      push_range(2, 2, 3'd5, pre_v, 1'b1, "loss_before");
      push_range(3, 10, 3'd0, post_v, 1'b1, "loss_mmcm");
      push_range(11, 11, 3'd1, post_v, 1'b1, "loss_wait");
      push_range(12, 12, 3'd2, post_v, 1'b1, "loss_stable_in");
      push_range(27, 27, 3'd2, post_v, 1'b1, "loss_stable_end");
      push_range(28, 28, 3'd3, post_v, 1'b1, "loss_idly");
      push_range(29, 29, 3'd4, post_v, 1'b1, "loss_rel_io");
      push_range(32, 32, 3'd4, post_v, 1'b1, "loss_rel_io_end");
      push_range(33, 33, 3'd5, post_v, 1'b1, "loss_run");
      base = saved_base;
      mmcm_locked = 1'b0;
      wait_until(d + 3);
      mmcm_locked = 1'b1;
      llc_model = post;
      $display("lock_loss %0d: expected count %0d", i + 1, llc_model);
      d += 34;
    end
    wait_until(d);
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      errors++; $display("FAIL lock_loss_saturate: got %0d want 255", lock_loss_cnt);
    end
  endtask

  task automatic test_async_reset();
    @(posedge sys_clk_bufg);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seq_state !== 3'd0 || rst_mmcm !== 1'b1 || rst_glb !== 1'b1 ||
        rst_io_n !== 1'b0 || rst_core_n !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: got st=%0d mmcm=%b glb=%b io_n=%b core_n=%b want 0 1 1 0 0",
               seq_state, rst_mmcm, rst_glb, rst_io_n, rst_core_n);
    end
    checks++;
    if (lock_loss_cnt !== 8'd0 || err_idelay_to !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_status: got llc=%0d err=%b want 0 0", lock_loss_cnt, err_idelay_to);
    end
    $display("test_async_reset: rst_n asserted between edges in RUN");
  endtask

  task automatic test_simultaneous();
    mmcm_locked = 1'b1;
    idelay_rdy  = 1'b1;
    @(negedge sys_clk_bufg);
    base = cyc + 1;
    push_range(0, 7, 3'd0, 8'd0, 1'b0, "sim_mmcm");
    push_range(8, 8, 3'd1, 8'd0, 1'b0, "sim_wait");
    push_range(9, 24, 3'd2, 8'd0, 1'b0, "sim_stable");
    push_range(25, 25, 3'd3, 8'd0, 1'b0, "sim_idly");
    push_range(26, 29, 3'd4, 8'd0, 1'b0, "sim_rel_io");
    push_range(30, 37, 3'd0, 8'd1, 1'b0, "sim_lock_wins");
    push_range(38, 40, 3'd1, 8'd1, 1'b0, "sim_wait_again");
    @(negedge sys_clk_bufg);
    rst_n = 1'b1;
    wait_until(base + 27);
    mmcm_locked = 1'b0;
    wait_until(base + 41);
    $display("test_simultaneous: lock loss on gap completion at 30");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_idelay_timeout();
    test_lock_loss_run();
    test_async_reset();
    test_simultaneous();
    @(negedge sys_clk_bufg);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
